// File: rtl/friscv_scoreboard_regfile.sv
// Multi-port register file with byte strobes, lowest-port write priority and a
// per-register reservation scoreboard for issue/writeback hazard tracking.
module friscv_scoreboard_regfile #(
  parameter int XLEN   = 32,
  parameter int RV32E  = 0,
  parameter int NB_WR  = 4,
  parameter int NB_RD  = 7,
  parameter int BYPASS = 1,
  localparam int REGNUM = (RV32E == 1) ? 16 : 32,
  localparam int NBYTE  = XLEN / 8,
  localparam int AW     = $clog2(REGNUM)
) (
  input  logic                   aclk,
  input  logic                   srst,
  input  logic [NB_WR-1:0]       wr_en,
  input  logic [5*NB_WR-1:0]     wr_addr,
  input  logic [XLEN*NB_WR-1:0]  wr_data,
  input  logic [NBYTE*NB_WR-1:0] wr_strb,
  input  logic [5*NB_RD-1:0]     rd_addr,
  output logic [XLEN*NB_RD-1:0]  rd_val,
  output logic [NB_RD-1:0]       rd_busy,
  input  logic                   rsv_valid,
  input  logic [4:0]             rsv_addr,
  output logic                   rsv_ready,
  output logic [REGNUM-1:0]      busy,
  output logic                   wr_collision
);

  logic [XLEN-1:0]   regs     [REGNUM];
  logic [XLEN-1:0]   regs_nxt [REGNUM];
  logic [REGNUM-1:0] claimed;
  logic [REGNUM-1:0] busy_q;
  logic [REGNUM-1:0] busy_nxt;
  logic              collision_q;
  logic              collision_now;
  logic              rsv_hit_wr;
  logic              rsv_accept;

  // Indexes 16..31 fall outside the file in the reduced configuration.
  function automatic logic in_range(input logic addr_msb);
    return (REGNUM == 32) || !addr_msb;
  endfunction

  // Scanning ports upward and claiming the register on first hit gives the
  // lowest-index enabled port priority.
  always_comb begin
    claimed = '0;
    for (int i = 0; i < REGNUM; i++) regs_nxt[i] = regs[i];
    for (int i = 1; i < REGNUM; i++) begin
      for (int p = 0; p < NB_WR; p++) begin
        if (!claimed[i] && wr_en[p] && (wr_addr[p*5 +: 5] == 5'(i))) begin
          claimed[i] = 1'b1;
          for (int b = 0; b < NBYTE; b++) begin
            if (wr_strb[p*NBYTE + b])
              regs_nxt[i][b*8 +: 8] = wr_data[p*XLEN + b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    collision_now = 1'b0;
    for (int p = 0; p < NB_WR; p++) begin
      for (int q = p + 1; q < NB_WR; q++) begin
        if (wr_en[p] && wr_en[q] && (wr_addr[p*5 +: 5] == wr_addr[q*5 +: 5])
            && (wr_addr[p*5 +: 5] != 5'd0))
          collision_now = 1'b1;
      end
    end
  end

  always_comb begin
    rsv_hit_wr = 1'b0;
    for (int p = 0; p < NB_WR; p++) begin
      if (wr_en[p] && (wr_addr[p*5 +: 5] == rsv_addr)) rsv_hit_wr = 1'b1;
    end
  end

  // Out-of-range and x0 reservations are acknowledged but never tracked.
  assign rsv_ready = rsv_valid &&
                     ((rsv_addr == 5'd0) || !in_range(rsv_addr[4]) ||
                      !busy_q[rsv_addr[AW-1:0]] || rsv_hit_wr);
  assign rsv_accept = rsv_ready && (rsv_addr != 5'd0) && in_range(rsv_addr[4]);

  // A reservation accepted alongside a release of the same register wins.
  always_comb begin
    busy_nxt = busy_q;
    for (int i = 1; i < REGNUM; i++) begin
      for (int p = 0; p < NB_WR; p++) begin
        if (wr_en[p] && (wr_addr[p*5 +: 5] == 5'(i))) busy_nxt[i] = 1'b0;
      end
    end
    if (rsv_accept) busy_nxt[rsv_addr[AW-1:0]] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      for (int i = 0; i < REGNUM; i++) regs[i] <= '0;
      busy_q      <= '0;
      collision_q <= 1'b0;
    end else begin
      for (int i = 0; i < REGNUM; i++) regs[i] <= regs_nxt[i];
      busy_q      <= busy_nxt;
      collision_q <= collision_q | collision_now;
    end
  end

  always_comb begin
    rd_val  = '0;
    rd_busy = '0;
    for (int k = 0; k < NB_RD; k++) begin
      logic [4:0] ra;
      ra = rd_addr[k*5 +: 5];
      if (!srst && in_range(ra[4])) begin
        rd_val[k*XLEN +: XLEN] = (BYPASS == 1) ? regs_nxt[ra[AW-1:0]] : regs[ra[AW-1:0]];
        rd_busy[k]             = busy_q[ra[AW-1:0]];
      end
    end
  end

  assign busy         = srst ? '0 : busy_q;
  assign wr_collision = !srst && collision_q;

endmodule

// File: tb/tb_friscv_scoreboard_regfile.sv
// Bench for friscv_scoreboard_regfile: a default instance and a reduced
// (16-register, unbypassed) instance share stimulus and are checked each cycle.
module tb_friscv_scoreboard_regfile;

  localparam int NB_WR = 4;
  localparam int NB_RD = 7;

  logic               aclk = 1'b0;
  logic               srst;
  logic [NB_WR-1:0]   wr_en;
  logic [5*NB_WR-1:0] wr_addr;
  logic [32*NB_WR-1:0] wr_data;
  logic [4*NB_WR-1:0] wr_strb;
  logic [5*NB_RD-1:0] rd_addr;
  logic               rsv_valid;
  logic [4:0]         rsv_addr;

  logic [32*NB_RD-1:0] rd_val0, rd_val1;
  logic [NB_RD-1:0]    rd_busy0, rd_busy1;
  logic                ready0, ready1;
  logic [31:0]         busy0;
  logic [15:0]         busy1;
  logic                col0, col1;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  always #5 aclk = ~aclk;

  friscv_scoreboard_regfile #(.XLEN(32), .RV32E(0), .NB_WR(NB_WR), .NB_RD(NB_RD), .BYPASS(1)) u_dut (
    .aclk(aclk), .srst(srst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_addr(rd_addr), .rd_val(rd_val0), .rd_busy(rd_busy0),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(ready0), .busy(busy0),
    .wr_collision(col0));

  friscv_scoreboard_regfile #(.XLEN(32), .RV32E(1), .NB_WR(NB_WR), .NB_RD(NB_RD), .BYPASS(0)) u_e (
    .aclk(aclk), .srst(srst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_addr(rd_addr), .rd_val(rd_val1), .rd_busy(rd_busy1),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(ready1), .busy(busy1),
    .wr_collision(col1));

  // Reference state: instance 0 = 32 regs bypassed, instance 1 = 16 regs registered reads.
  logic [31:0] m_reg  [2][32];
  logic        m_busy [2][32];
  logic        m_col  [2];

  function automatic int regn(int n);
    return (n == 0) ? 32 : 16;
  endfunction

  function automatic logic targeted(int idx);
    for (int p = 0; p < NB_WR; p++)
      if (wr_en[p] && int'(wr_addr[p*5 +: 5]) == idx) return 1'b1;
    return 1'b0;
  endfunction

  // Value after the edge: apply ports highest first so the lowest port lands last.
  function automatic logic [31:0] m_merged(int n, int idx);
    logic [31:0] v;
    if (idx == 0 || idx >= regn(n)) return 32'h0;
    v = m_reg[n][idx];
    for (int p = NB_WR - 1; p >= 0; p--)
      if (wr_en[p] && int'(wr_addr[p*5 +: 5]) == idx)
        for (int b = 0; b < 4; b++)
          if (wr_strb[p*4 + b]) v[b*8 +: 8] = wr_data[p*32 + b*8 +: 8];
    return v;
  endfunction

  function automatic logic [31:0] exp_val(int n, int k);
    int a;
    a = int'(rd_addr[k*5 +: 5]);
    if (srst || a >= regn(n)) return 32'h0;
    return (n == 0) ? m_merged(n, a) : m_reg[n][a];
  endfunction

  function automatic logic exp_rbusy(int n, int k);
    int a;
    a = int'(rd_addr[k*5 +: 5]);
    if (srst || a >= regn(n)) return 1'b0;
    return m_busy[n][a];
  endfunction

  function automatic logic exp_ready(int n);
    int a;
    a = int'(rsv_addr);
    if (!rsv_valid) return 1'b0;
    if (a == 0 || a >= regn(n)) return 1'b1;
    return !m_busy[n][a] || targeted(a);
  endfunction

  function automatic logic exp_col_now();
    for (int p = 0; p < NB_WR; p++)
      for (int q = p + 1; q < NB_WR; q++)
        if (wr_en[p] && wr_en[q] && wr_addr[p*5 +: 5] == wr_addr[q*5 +: 5] && wr_addr[p*5 +: 5] != 5'd0)
          return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic acc;
    for (int n = 0; n < 2; n++) begin
      if (srst) begin
        for (int i = 0; i < 32; i++) begin
          m_reg[n][i] = 32'h0;
          m_busy[n][i] = 1'b0;
        end
        m_col[n] = 1'b0;
      end else begin
        acc = exp_ready(n);
        m_col[n] = m_col[n] | exp_col_now();
        for (int i = 1; i < regn(n); i++) begin
          m_reg[n][i] = m_merged(n, i);
          if (targeted(i)) m_busy[n][i] = 1'b0;
        end
        if (acc && rsv_addr != 5'd0 && int'(rsv_addr) < regn(n)) m_busy[n][int'(rsv_addr)] = 1'b1;
      end
    end
  endtask

  always @(posedge aclk) model_step();

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] val0(int k); return rd_val0[k*32 +: 32]; endfunction
  function automatic logic [31:0] val1(int k); return rd_val1[k*32 +: 32]; endfunction

  function automatic logic [31:0] exp_busy(int n);
    logic [31:0] v;
    v = '0;
    if (!srst) for (int i = 0; i < regn(n); i++) v[i] = m_busy[n][i];
    return v;
  endfunction

  always @(negedge aclk) begin
    if (chk_en) begin
      for (int k = 0; k < NB_RD; k++) begin
        chk($sformatf("rd_val0[%0d]", k), 64'(val0(k)), 64'(exp_val(0, k)));
        chk($sformatf("rd_val1[%0d]", k), 64'(val1(k)), 64'(exp_val(1, k)));
        chk($sformatf("rd_busy0[%0d]", k), 64'(rd_busy0[k]), 64'(exp_rbusy(0, k)));
        chk($sformatf("rd_busy1[%0d]", k), 64'(rd_busy1[k]), 64'(exp_rbusy(1, k)));
      end
      chk("busy0", 64'(busy0), 64'(exp_busy(0)));
      chk("busy1", 64'(busy1), 64'(exp_busy(1)));
      chk("rsv_ready0", 64'(ready0), 64'(exp_ready(0)));
      chk("rsv_ready1", 64'(ready1), 64'(exp_ready(1)));
      chk("wr_collision0", 64'(col0), 64'(!srst && m_col[0]));
      chk("wr_collision1", 64'(col1), 64'(!srst && m_col[1]));
    end
  end

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rsv_valid = 1'b0; rsv_addr = 5'd0;
  endtask

  task automatic wr(int p, int a, logic [31:0] d, logic [3:0] s);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = 5'(a);
    wr_data[p*32 +: 32] = d;
    wr_strb[p*4 +: 4] = s;
  endtask

  task automatic rd(int p, int a);
    rd_addr[p*5 +: 5] = 5'(a);
  endtask

  task automatic rsv(int a);
    rsv_valid = 1'b1;
    rsv_addr = 5'(a);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1;
    rd_addr = '0;
    idle();
    @(posedge aclk);
    chk_en = 1'b1;
    #1;
    chk("reset busy0", 64'(busy0), 64'h0);
    chk("reset col0", 64'(col0), 64'h0);
    chk("reset rd_val0", 64'(val0(0)), 64'h0);
    step();
    srst = 1'b0;

    // Byte strobes
    wr(0, 5, 32'hAABBCCDD, 4'hF); rd(0, 5); #1;
    chk("bypass x5 first", 64'(val0(0)), 64'hAABBCCDD);
    chk("nobypass x5 first", 64'(val1(0)), 64'h0);
    step();
    idle(); wr(0, 5, 32'h11223344, 4'h5); #1;
    chk("bypass x5 merged", 64'(val0(0)), 64'hAA22CC44);
    chk("nobypass x5 old", 64'(val1(0)), 64'hAABBCCDD);
    step();
    idle(); #1;
    chk("x5 merged", 64'(val1(0)), 64'hAA22CC44);

    // x0 is hardwired
    wr(1, 0, 32'hFFFFFFFF, 4'hF); rd(1, 0); #1;
    chk("x0 bypass", 64'(val0(1)), 64'h0);
    step();
    idle();

    // Priority and collision
    wr(0, 7, 32'h1, 4'hF); wr(2, 7, 32'h2, 4'hF); rd(2, 7);
    step();
    idle(); #1;
    chk("x7 winner", 64'(val0(2)), 64'h1);
    chk("collision0", 64'(col0), 64'h1);
    step(); step();
    chk("collision sticky", 64'(col1), 64'h1);

    // Scoreboard reserve / blocked / release
    rsv(3); rd(1, 3); #1;
    chk("rsv x3 ready", 64'(ready0), 64'h1);
    step();
    chk("busy x3 set", 64'(busy0[3]), 64'h1);
    chk("rsv x3 again", 64'(ready0), 64'h0);
    chk("rd_busy x3", 64'(rd_busy0[1]), 64'h1);
    step();
    idle(); wr(1, 3, 32'h33, 4'hF); #1;
    chk("rd_busy no bypass", 64'(rd_busy0[1]), 64'h1);
    step();
    idle(); #1;
    chk("busy x3 cleared", 64'(busy0[3]), 64'h0);
    chk("x3 data", 64'(val0(1)), 64'h33);

    // Reserve and release in the same cycle
    rsv(9);
    step();
    idle(); rsv(9); wr(3, 9, 32'h99, 4'hF); rd(3, 9); #1;
    chk("rsv+rel ready", 64'(ready0), 64'h1);
    step();
    idle(); #1;
    chk("busy x9 kept", 64'(busy0[9]), 64'h1);
    chk("busy1 x9 kept", 64'(busy1[9]), 64'h1);
    chk("x9 data", 64'(val1(3)), 64'h99);

    // x0 reservation
    rsv(0); #1;
    chk("rsv x0 ready", 64'(ready0), 64'h1);
    step();
    idle(); #1;
    chk("x0 never busy", 64'(busy0[0]), 64'h0);

    // Bypass vs registered read
    wr(0, 4, 32'h55, 4'hF); rd(2, 4); #1;
    chk("bypass x4", 64'(val0(2)), 64'h55);
    chk("nobypass x4 old", 64'(val1(2)), 64'h0);
    step();
    idle(); #1;
    chk("nobypass x4 new", 64'(val1(2)), 64'h55);

    // Out-of-range indexes in the reduced file
    wr(1, 20, 32'hFF, 4'hF); rsv(20); rd(4, 20);
    step();
    idle(); #1;
    chk("x20 rv32e val", 64'(val1(4)), 64'h0);
    chk("x20 rv32e busy", 64'(rd_busy1[4]), 64'h0);
    chk("x20 full val", 64'(val0(4)), 64'hFF);
    chk("x20 full busy", 64'(rd_busy0[4]), 64'h1);
    rsv(12);
    step();
    idle(); #1;
    chk("busy1 x12", 64'(busy1[12]), 64'h1);
    srst = 1'b1;
    step();
    chk("srst busy0", 64'(busy0), 64'h0);
    chk("srst busy1", 64'(busy1), 64'h0);
    chk("srst col0", 64'(col0), 64'h0);
    srst = 1'b0;
    step();
    chk("post srst x5", 64'(val1(0)), 64'h0);

    // Directed multi-port sweep
    for (int i = 0; i < 24; i++) begin
      idle();
      for (int p = 0; p < NB_WR; p++) begin
        if (((i + p) % 3) != 0)
          wr(p, (i * 3 + p * 5) % 32, 32'h01020304 * (i + 1) + 32'(p), 4'((i + p * 3) % 16));
      end
      if ((i % 2) == 0) rsv((i * 7) % 32);
      for (int k = 0; k < NB_RD; k++) rd(k, (i + k * 4) % 32);
      step();
    end
    idle();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
